cx_stream_hub: RTL and testbench



---
 rtl/cx_stream_hub.sv | 149 ++++++++++++++
 tb/tb_cx_stream_hub.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cx_stream_hub.sv
// cx_stream_hub: DEPTH-entry FIFO dealt round-robin to NUM_CH channels plus a step-programmable counter source.
// Push-to-valid 1 cycle, a stalled selected channel blocks all; CX_STREAM_HUB_STATS_EN adds drop_cnt/occ_hwm.
module cx_stream_hub #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16,
  parameter int CFG_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NUM_CH-1:0]       out_vld,
  input  logic [NUM_CH-1:0]       out_rdy,
  output logic [DATA_W-1:0]       out_data,
`ifdef CX_STREAM_HUB_STATS_EN
  output logic [15:0]             drop_cnt,
  output logic [$clog2(DEPTH):0]  occ_hwm,
`endif
  output logic                    cnt_vld,
  input  logic                    cnt_rdy,
  output logic [CNT_W-1:0]        cnt_data,
  input  logic                    cfg_req,
  input  logic [CFG_W-1:0]        cfg_data,
  output logic                    cfg_ack
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {CFG_IDLE, CFG_ACK} cfg_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CHW-1:0]    ch_ptr_q, ch_ptr_d;
  logic              empty, full, push, pop;

  logic              cnt_vld_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  step_q, step_d;
  cfg_state_e        state_q, state_d;

  // Same index with opposite wrap bits means the write pointer has lapped the read pointer.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_vld && !full;
  assign pop   = !empty && out_rdy[ch_ptr_q];

  assign in_rdy   = !full;
  assign out_vld  = empty ? '0 : (NUM_CH'(1) << ch_ptr_q);
  assign out_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    ch_ptr_d = ch_ptr_q;
    if (pop) begin
      ch_ptr_d = (ch_ptr_q == CHW'(NUM_CH - 1)) ? '0 : ch_ptr_q + CHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ch_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ch_ptr_q <= ch_ptr_d;
    end
  end

  // The increment reads step_q, so a step loaded in the same cycle only affects later handshakes.
  assign cnt_d    = (cnt_vld_q && cnt_rdy) ? cnt_q + step_q : cnt_q;
  assign cnt_vld  = cnt_vld_q;
  assign cnt_data = cnt_q;
  assign cfg_ack  = (state_q == CFG_ACK);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_req) begin
          step_d  = cfg_data[CNT_W-1:0];
          state_d = CFG_ACK;
        end
      end
      CFG_ACK: begin
        if (!cfg_req) state_d = CFG_IDLE;
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_vld_q <= 1'b0;
      cnt_q     <= '0;
      step_q    <= CNT_W'(1);
      state_q   <= CFG_IDLE;
    end else begin
      cnt_vld_q <= 1'b1;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      state_q   <= state_d;
    end
  end

  generate
    if (CFG_W > CNT_W) begin : g_cfg_hi
      logic unused_cfg_hi;
      assign unused_cfg_hi = ^cfg_data[CFG_W-1:CNT_W];
    end
  endgenerate

`ifdef CX_STREAM_HUB_STATS_EN
  logic [15:0] drop_q;
  logic [AW:0] hwm_q;
  logic [AW:0] occ_next;

  assign occ_next = wr_ptr_d - rd_ptr_d;
  assign drop_cnt = drop_q;
  assign occ_hwm  = hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      hwm_q  <= '0;
    end else begin
      if (in_vld && full && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (occ_next > hwm_q) hwm_q <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_cx_stream_hub.sv
// Bench for cx_stream_hub: directed phases plus a randomized phase, checked every cycle against a queue-based model.
module tb_cx_stream_hub;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CFG_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] in_data;
  logic [NUM_CH-1:0] out_vld;
  logic [NUM_CH-1:0] out_rdy;
  logic [DATA_W-1:0] out_data;
  logic              cnt_vld;
  logic              cnt_rdy;
  logic [CNT_W-1:0]  cnt_data;
  logic              cfg_req;
  logic [CFG_W-1:0]  cfg_data;
  logic              cfg_ack;
`ifdef CX_STREAM_HUB_STATS_EN
  logic [15:0]             drop_cnt;
  logic [$clog2(DEPTH):0]  occ_hwm;
`endif

  cx_stream_hub #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CFG_W(CFG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
`ifdef CX_STREAM_HUB_STATS_EN
    .drop_cnt(drop_cnt), .occ_hwm(occ_hwm),
`endif
    .cnt_vld(cnt_vld), .cnt_rdy(cnt_rdy), .cnt_data(cnt_data),
    .cfg_req(cfg_req), .cfg_data(cfg_data), .cfg_ack(cfg_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue, channel chosen by how many entries have left.
  logic [DATA_W-1:0] q[$];
  int                popped;
  logic [CNT_W-1:0]  m_cnt;
  logic [CNT_W-1:0]  m_step;
  logic              m_ack;
  logic              m_cntv;
  int                m_drop;
  int                m_hwm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    popped = 0;
    m_cnt  = '0;
    m_step = CNT_W'(1);
    m_ack  = 1'b0;
    m_cntv = 1'b0;
    m_drop = 0;
    m_hwm  = 0;
  endtask

  // Called one time unit after inputs are driven; checks outputs, advances the model, crosses one edge.
  task automatic cycle();
    logic [NUM_CH-1:0] ev;
    logic [DATA_W-1:0] dummy;
    int ch;
    bit do_pop, do_push;
    #1;
    ch = popped % NUM_CH;
    ev = '0;
    if (q.size() != 0) ev[ch] = 1'b1;
    check("in_rdy", 32'(in_rdy), 32'(q.size() < DEPTH));
    check("out_vld", 32'(out_vld), 32'(ev));
    if (q.size() != 0) check("out_data", out_data, q[0]);
    check("cnt_vld", 32'(cnt_vld), 32'(m_cntv));
    check("cnt_data", 32'(cnt_data), 32'(m_cnt));
    check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
`ifdef CX_STREAM_HUB_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("occ_hwm", 32'(occ_hwm), 32'(m_hwm));
`endif
    do_pop  = (q.size() != 0) && out_rdy[ch];
    do_push = in_vld && (q.size() < DEPTH);
    if (in_vld && q.size() >= DEPTH && m_drop < 16'hFFFF) m_drop++;
    if (m_cntv && cnt_rdy) m_cnt = m_cnt + m_step;
    if (!m_ack && cfg_req) begin
      m_step = cfg_data[CNT_W-1:0];
      m_ack  = 1'b1;
    end else if (m_ack && !cfg_req) begin
      m_ack = 1'b0;
    end
    if (do_pop) begin
      dummy = q.pop_front();
      popped++;
    end
    if (do_push) q.push_back(in_data);
    if (q.size() > m_hwm) m_hwm = q.size();
    m_cntv = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_step(input logic [CNT_W-1:0] s);
    cfg_req  = 1'b1;
    cfg_data = CFG_W'(s);
    cycle();
    cfg_data = $urandom;
    cycle();
    cfg_req = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    in_vld = 1'b0; in_data = '0; out_rdy = '0;
    cnt_rdy = 1'b0; cfg_req = 1'b0; cfg_data = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_cnt_vld", 32'(cnt_vld), 32'd0);
    check("rst_cnt_data", 32'(cnt_data), 32'd0);
    check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Counter with default step, then step 0x10 over a full 4-phase handshake.
    cnt_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("cnt_default_step", 32'(cnt_data), 32'(i));
    end
    cnt_rdy = 1'b0;
    cfg_req = 1'b1; cfg_data = 32'h10;
    cycle();
    check("cfg_ack_rise", 32'(cfg_ack), 32'd1);
    cfg_req = 1'b0;
    cycle();
    check("cfg_ack_fall", 32'(cfg_ack), 32'd0);
    cnt_rdy = 1'b1;
    cycle();
    check("cnt_step_10a", 32'(cnt_data), 32'h13);
    cycle();
    check("cnt_step_10b", 32'(cnt_data), 32'h23);
    cnt_rdy = 1'b0;

    // Back-to-back A0..A5 with every channel ready.
    out_rdy = '1;
    for (int i = 0; i < 6; i++) begin
      in_vld = 1'b1; in_data = 32'hA0 + 32'(i);
      cycle();
    end
    in_vld = 1'b0;
    repeat (3) cycle();

    // All channels stalled: fill, overflow attempts, then release channel 0 only.
    out_rdy = '0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_data = $urandom;
      cycle();
      if (i == 3) check("full_in_rdy", 32'(in_rdy), 32'd0);
    end
    repeat (2) cycle();
    in_vld = 1'b0;
    out_rdy = NUM_CH'(1);
    repeat (3) cycle();
    check("stall_on_ch1", 32'(out_vld), 32'(1 << ((popped) % NUM_CH)));
    out_rdy = '1;
    repeat (5) cycle();

    // Wrap: bring counter to 0xFFF8, then step 0x10; then same-cycle load and handshake; then step 0.
    load_step(16'hFFF8 - m_cnt);
    cnt_rdy = 1'b1;
    cycle();
    cnt_rdy = 1'b0;
    check("cnt_fff8", 32'(cnt_data), 32'hFFF8);
    load_step(16'h0010);
    cnt_rdy = 1'b1;
    cycle();
    check("cnt_wrap", 32'(cnt_data), 32'h0008);
    cfg_req = 1'b1; cfg_data = 32'h3;
    cycle();
    check("cnt_old_step", 32'(cnt_data), 32'h0018);
    cycle();
    check("cnt_new_step", 32'(cnt_data), 32'h001B);
    cfg_req = 1'b0; cnt_rdy = 1'b0;
    cycle();
    load_step(16'h0000);
    cnt_rdy = 1'b1;
    repeat (2) cycle();
    check("cnt_step_zero", 32'(cnt_data), 32'h001B);

    // Randomized traffic on every input.
    for (int i = 0; i < 400; i++) begin
      in_vld   = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      out_rdy  = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      cnt_rdy  = 1'($urandom_range(0, 1));
      cfg_req  = ($urandom_range(0, 7) == 0) ? ~cfg_req : cfg_req;
      cfg_data = $urandom;
      cycle();
    end
    cfg_req = 1'b0; in_vld = 1'b0; cnt_rdy = 1'b0;
    repeat (4) cycle();

    // Asynchronous reset with two entries buffered and cfg_ack high.
    out_rdy = '0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1; in_data = $urandom;
      cycle();
    end
    in_vld = 1'b0;
    cfg_req = 1'b1; cfg_data = $urandom;
    cycle();
    cycle();
    check("pre_rst_ack", 32'(cfg_ack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_vld", 32'(out_vld), 32'd0);
    check("async_cfg_ack", 32'(cfg_ack), 32'd0);
    check("async_in_rdy", 32'(in_rdy), 32'd1);
    check("async_cnt_vld", 32'(cnt_vld), 32'd0);
    reset_model();
    cfg_req = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    out_rdy = '1;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 32'hB0 + 32'(i);
      cycle();
    end
    in_vld = 1'b0;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
